// File: rtl/mux4_rr_sequencer.sv
// rtl/mux4_rr_sequencer.sv - round-robin sequencer sharing a 4:1 bit mux among four requesters
//
// Grants the mux to one requester at a time for a burst of BURST_LEN samples.
// It shifts the mux output into a word and tags the word with the owning requester.
// Optional build macro: MUX4_RR_PARITY_EN adds the word_par output (even parity of word_out).
//
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   req[3:0]   - request level per requester
//   y_in       - mux output y, sampled on clk while granted
//   sel[1:0]   - mux select (drives mux port a)
//   gnt[3:0]   - one-hot grant, zero when idle
//   busy       - burst in progress
//   word_out   - captured word, first sample in MSB
//   word_src   - requester index owning word_out
//   word_valid - one-cycle pulse on word completion
//   word_par   - XOR of word_out bits (MUX4_RR_PARITY_EN only)
module mux4_rr_sequencer #(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           req,
  input  logic                 y_in,
  output logic [1:0]           sel,
  output logic [3:0]           gnt,
  output logic                 busy,
  output logic [BURST_LEN-1:0] word_out,
  output logic [1:0]           word_src,
  output logic                 word_valid
`ifdef MUX4_RR_PARITY_EN
  ,
  output logic                 word_par
`endif
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

  state_t               state, state_next;
  logic [1:0]           last, last_next;
  logic [1:0]           sel_next, word_src_next;
  logic [3:0]           gnt_next;
  logic                 busy_next, word_valid_next;
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic [BURST_LEN-1:0] shift, shift_next, word_out_next, captured;
  logic [1:0]           winner, cand;
  logic                 found;
`ifdef MUX4_RR_PARITY_EN
  logic                 word_par_next;
`endif

  // Shift register value including the sample taken at this edge.
  assign captured = {shift[BURST_LEN-2:0], y_in};

  // Round-robin search starting just after the last owner; the last owner is tried last.
  always_comb begin
    winner = last;
    cand   = last;
    found  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = last + 2'(k);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_next      = state;
    last_next       = last;
    sel_next        = sel;
    gnt_next        = gnt;
    busy_next       = busy;
    cnt_next        = cnt;
    shift_next      = shift;
    word_out_next   = word_out;
    word_src_next   = word_src;
    word_valid_next = 1'b0;
`ifdef MUX4_RR_PARITY_EN
    word_par_next   = word_par;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          sel_next   = winner;
          gnt_next   = 4'b0001 << winner;
          busy_next  = 1'b1;
          cnt_next   = '0;
          state_next = GRANT;
        end else begin
          gnt_next  = 4'b0000;
          busy_next = 1'b0;
        end
      end
      GRANT: begin
        if (!req[sel]) begin
          // Owner withdrew: drop the partial word, owner goes to the back of the line.
          last_next  = sel;
          gnt_next   = 4'b0000;
          busy_next  = 1'b0;
          state_next = IDLE;
        end else begin
          shift_next = captured;
          cnt_next   = cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            word_out_next   = captured;
            word_src_next   = sel;
            word_valid_next = 1'b1;
`ifdef MUX4_RR_PARITY_EN
            word_par_next   = ^captured;
`endif
            last_next       = sel;
            gnt_next        = 4'b0000;
            busy_next       = 1'b0;
            state_next      = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last       <= 2'd3;
      sel        <= 2'd0;
      gnt        <= 4'b0000;
      busy       <= 1'b0;
      cnt        <= '0;
      shift      <= '0;
      word_out   <= '0;
      word_src   <= 2'd0;
      word_valid <= 1'b0;
`ifdef MUX4_RR_PARITY_EN
      word_par   <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      last       <= last_next;
      sel        <= sel_next;
      gnt        <= gnt_next;
      busy       <= busy_next;
      cnt        <= cnt_next;
      shift      <= shift_next;
      word_out   <= word_out_next;
      word_src   <= word_src_next;
      word_valid <= word_valid_next;
`ifdef MUX4_RR_PARITY_EN
      word_par   <= word_par_next;
`endif
    end
  end

endmodule

// File: doc/mux4_rr_sequencer.md
Name: mux4_rr_sequencer

Overview:
Round-robin sequencer that shares the 4:1 bit multiplexer (2-bit select `a`, 4-bit data `d`, 1-bit output `y`) among four requesters. Each requester drives one mux data input.
- It arbitrates fairly, drives the mux select, and holds the grant for a fixed burst.
- During the burst it serially captures the mux output into a word and tags the word with its source.
- It sits between the requester logic and the mux instance.

Parameters:
- BURST_LEN, 4, samples captured per grant; legal range 2..15.
- CNT_W, 4, width of the burst counter; must satisfy 2^CNT_W > BURST_LEN.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request per requester; bit i is requester i.
- y_in  input  1  mux output `y`, sampled on clk.
- sel  output  2  mux select; connects to mux port `a`.
- gnt  output  4  one-hot grant; all-zero when no grant.
- busy  output  1  high while a burst is in progress.
- word_out  output  BURST_LEN  captured word; first sample is in the MSB.
- word_src  output  2  index of the requester that owns word_out.
- word_valid  output  1  one-cycle pulse marking a completed word.

Behaviour:
- Reset is asynchronous and active-low (rst_n = 0), one clock (clk).
- Reset values: state=IDLE, sel=0, gnt=0, busy=0, word_out=0, word_src=0, word_valid=0, cnt=0, last=3. With last=3, requester 0 wins first.
- Reset asserted mid-burst: the burst is discarded and no word_valid is produced.
- States: IDLE, GRANT.
- IDLE:
  - If req≠0, pick the first set bit in search order last+1, last+2, last+3, last (mod 4).
  - At the clock edge: sel=winner, gnt=one-hot(winner), busy=1, cnt=0, state→GRANT.
  - If req=0, stay in IDLE with gnt=0 and busy=0.
- GRANT, each edge:
  - shift register ← {shift[BURST_LEN-2:0], y_in}.
  - cnt ← cnt+1.
- Burst completion, at the edge where cnt==BURST_LEN-1:
  - word_out ← final shift value, including this sample.
  - word_src ← sel; word_valid ← 1 for exactly one cycle.
  - last ← sel; gnt ← 0; busy ← 0; state → IDLE.
- Burst abort: if req[sel] is 0 when sampled in GRANT before the final sample:
  - No word_valid is produced; word_out and word_src keep their previous values.
  - last ← sel, so the aborting requester loses priority.
  - gnt ← 0, busy ← 0, state → IDLE.
  - Abort takes precedence over the final-sample completion in the same cycle.
- Latency:
  - Request seen at edge E0 → gnt high after E0.
  - Samples taken at E1..E_BURST_LEN.
  - word_valid high for the cycle after E_BURST_LEN.
  - Next grant issued no earlier than E_BURST_LEN+1 (one mandatory IDLE bubble).
- sel is stable for the whole grant. sel holds its last value while in IDLE; the mux output is ignored in IDLE.
- Requests arriving during a burst are held off and not queued. Only the req levels at the IDLE arbitration edge count.
- word_valid is never high on two consecutive cycles.

Optional Feature:
- Macro: MUX4_RR_PARITY_EN.
- When defined:
  - Extra output word_par (1 bit), registered alongside word_out, equal to the XOR of all captured bits (even parity).
  - word_par resets to 0.
- When not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Single requester: reset; req=4'b0001; y_in=1,0,1,1 on E1..E4 → sel=0 and gnt=0001 during E1..E4; word_out=4'b1011, word_src=0, word_valid=1 for exactly one cycle; gnt=0 after the burst.
- Round-robin fairness: req=4'b1111 held constant → word_src sequence 0,1,2,3,0; each word_valid separated by 5 cycles.
- Skip idle requesters: req=4'b1010 after reset → grants go to requester 1, then 3, then 1; sel is 1,3,1.
- Abort: req=4'b0100 granted; drop req[2] after 2 samples → no word_valid, word_out unchanged; with req=4'b0101 re-raised, the next grant goes to requester 0.
- Reset mid-burst: assert rst_n=0 asynchronously during cycle 3 of a burst → gnt, busy and word_valid go to 0 immediately without waiting for clk; after release with req=4'b0001, a normal burst resumes.
- With MUX4_RR_PARITY_EN defined: captured word 4'b1011 → word_par=1; captured word 4'b1001 → word_par=0.
